bcd_decimal_decoder: RTL and testbench

- Counterpart to the team's decimal-to-binary encoder: accepts a packed multi-digit BCD word and emits each digit as a 10-bit one-hot decimal code, one digit per handshake.
- Sits between arithmetic/counter logic that produces BCD and display/indicator logic that consumes one-hot decimal lines.
- Detects illegal BCD codes (1010–1111) per digit and keeps a saturating error count.

---
 rtl/bcd_decimal_decoder_pkg.sv | 13 +
 rtl/bcd_onehot_digit.sv | 22 ++
 rtl/bcd_decimal_decoder.sv | 108 ++++++++++
 tb/tb_bcd_decimal_decoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_decimal_decoder_pkg.sv
// Shared definitions for the BCD-to-one-hot decimal decoder: FSM encoding and
// the constants used by the top level and its digit decoder.
package bcd_decimal_decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int BCD_MAX  = 9;
    localparam int ERRCNT_W = 8;

endpackage

// File: rtl/bcd_onehot_digit.sv
// Combinational decode of one BCD nibble to a 10-bit one-hot decimal code;
// codes above 9 produce an all-zero code and raise error.
module bcd_onehot_digit
    import bcd_decimal_decoder_pkg::*;
(
    input  logic [3:0] digit,
    output logic [9:0] onehot,
    output logic       error
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        onehot = '0;
        error  = 1'b0;
        if (digit <= 4'(BCD_MAX)) begin
            onehot = 10'd1 << digit;
        end else begin
            error = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_decimal_decoder.sv
// Serialises a packed BCD word into one-hot decimal digits, most significant
// first, over a valid/ready handshake; counts illegal digits with saturation.
module bcd_decimal_decoder
    import bcd_decimal_decoder_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int IDXW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9:0]          out_decimal,
    output logic [IDXW-1:0]     out_index,
    output logic                out_last,
    output logic                out_error,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int W = 4 * DIGITS;
    localparam logic [ERRCNT_W-1:0] ERR_MAX = '1;

    state_t       state;
    logic [W-1:0] sreg;
    logic [W-1:0] sreg_next;
    logic [9:0]   dec_next;
    logic         err_next;
    logic         accept;
    logic         take;

    assign accept = (state == IDLE) && in_valid;
    assign take   = (state == EMIT) && out_valid && out_ready;

    // The decoder looks at the next shift-register value so the one-hot code
    // can be registered alongside the digit it belongs to.
    always_comb begin
        sreg_next = sreg;
        if (accept) begin
            sreg_next = in_bcd;
        end else if (take && !out_last) begin
            sreg_next = sreg << 4;
        end
    end

    bcd_onehot_digit u_digit (
        .digit  (sreg_next[W-1 -: 4]),
        .onehot (dec_next),
        .error  (err_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_decimal <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
            out_error   <= 1'b0;
            err_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= EMIT;
                        sreg        <= sreg_next;
                        in_ready    <= 1'b0;
                        out_valid   <= 1'b1;
                        out_decimal <= dec_next;
                        out_error   <= err_next;
                        out_index   <= IDXW'(DIGITS - 1);
                        out_last    <= 1'b0;
                    end
                end
                EMIT: begin
                    if (take) begin
                        if (out_error && err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (out_last) begin
                            state       <= IDLE;
                            sreg        <= '0;
                            in_ready    <= 1'b1;
                            out_valid   <= 1'b0;
                            out_decimal <= '0;
                            out_index   <= '0;
                            out_last    <= 1'b0;
                            out_error   <= 1'b0;
                        end else begin
                            sreg        <= sreg_next;
                            out_decimal <= dec_next;
                            out_error   <= err_next;
                            out_index   <= out_index - 1'b1;
                            out_last    <= (out_index == IDXW'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_decimal_decoder.sv
// Self-checking bench for bcd_decimal_decoder: table vectors with hand-derived
// one-hot codes, random words against a digit-arithmetic model, and reset,
// backpressure, ignored-input and saturation sequences.
module tb_bcd_decimal_decoder;

    localparam int DIGITS = 4;
    localparam int IDXW   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_bcd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [9:0]  out_decimal;
    logic [1:0]  out_index;
    logic        out_last;
    logic        out_error;
    logic [7:0]  err_count;

    int pass_cnt = 0;
    int total    = 0;
    int err_model = 0;

    always #5 clk = ~clk;

    bcd_decimal_decoder #(.DIGITS(DIGITS), .IDXW(IDXW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bcd      (in_bcd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_decimal (out_decimal),
        .out_index   (out_index),
        .out_last    (out_last),
        .out_error   (out_error),
        .err_count   (err_count)
    );

    typedef struct {
        logic [15:0]       word;
        int                stall;
        bit                noise;
        logic [0:3][9:0]   exp_dec;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference: digit k of the word is (w / 16^k) mod 16; legal values map to 2^v.
    function automatic int digit_of(input logic [15:0] w, input int k);
        return (int'(w) >> (4 * k)) % 16;
    endfunction

    function automatic logic [9:0] ref_dec(input int v);
        return (v <= 9) ? 10'(1 << v) : 10'd0;
    endfunction

    task automatic run_word(input logic [15:0] w, input int stall_first, input bit rnd,
                            input bit noise, input bit has_exp, input logic [0:3][9:0] exp_dec);
        int cyc;
        int nill;
        int k;
        int v;
        int st;
        int stalls;
        int t;
        in_bcd   = w;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cyc = 1;
        in_valid = noise;
        if (noise) in_bcd = 16'($urandom);
        nill = 0;
        stalls = 0;
        for (int i = 0; i < DIGITS; i++) begin
            k  = DIGITS - 1 - i;
            v  = digit_of(w, k);
            st = (i == 0) ? stall_first : 0;
            if (rnd) st = $urandom_range(0, 2);
            stalls += st;
            out_ready = (st == 0);
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_decimal", 32'(out_decimal), 32'(ref_dec(v)));
            check("out_index", 32'(out_index), 32'(k));
            check("out_last", 32'(out_last), 32'(k == 0));
            check("out_error", 32'(out_error), 32'(v > 9));
            if (has_exp) check("dec_table", 32'(out_decimal), 32'(exp_dec[i]));
            for (int s = 0; s < st; s++) begin
                @(posedge clk); #1; cyc++;
                check("held_decimal", 32'(out_decimal), 32'(ref_dec(v)));
                check("held_index", 32'(out_index), 32'(k));
            end
            out_ready = 1'b1;
            if (i == DIGITS - 1) in_valid = 1'b0;
            @(posedge clk); #1; cyc++;
            if (v > 9) nill++;
        end
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("word_cycles", 32'(cyc), 32'(DIGITS + stalls + 1));
        err_model = (err_model + nill > 255) ? 255 : err_model + nill;
        check("err_count", 32'(err_count), 32'(err_model));
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{word: 16'h1905, stall: 0, noise: 1'b0, exp_dec: {10'h002, 10'h200, 10'h001, 10'h020}};
        vecs[1] = '{word: 16'h0042, stall: 3, noise: 1'b0, exp_dec: {10'h001, 10'h001, 10'h010, 10'h004}};
        vecs[2] = '{word: 16'hA9F3, stall: 0, noise: 1'b0, exp_dec: {10'h000, 10'h200, 10'h000, 10'h008}};
        vecs[3] = '{word: 16'h9876, stall: 1, noise: 1'b1, exp_dec: {10'h200, 10'h100, 10'h080, 10'h040}};
        vecs[4] = '{word: 16'h0000, stall: 0, noise: 1'b1, exp_dec: {10'h001, 10'h001, 10'h001, 10'h001}};

        // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
        #3 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_out_decimal", 32'(out_decimal), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_word(vecs[i].word, vecs[i].stall, 1'b0, vecs[i].noise, 1'b1, vecs[i].exp_dec);
            if (i == 2) check("err_after_a9f3", 32'(err_count), 32'd2);
        end

        // Reset after the second digit of 16'h1234 discards the rest of the word.
        in_bcd = 16'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_first_dec", 32'(out_decimal), 32'h002);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_third_index", 32'(out_index), 32'd1);
        #3 rst = 1'b1;
        #1;
        err_model = 0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        check("mid_rst_out_decimal", 32'(out_decimal), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        run_word(16'h5678, 0, 1'b0, 1'b0, 1'b0, '0);

        for (int n = 0; n < 30; n++) begin
            run_word(16'($urandom), 0, 1'b1, n[0], 1'b0, '0);
        end

        for (int n = 0; n < 132; n++) begin
            run_word(16'hFFFF, 0, 1'b0, 1'b0, 1'b0, '0);
        end
        check("err_saturated", 32'(err_count), 32'd255);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
